// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG scan master: sequencer states, IR opcodes
// and the TCK pulse count of each fixed-length phase.
package jtag_pkg;

    localparam int IR_W = 4;

    localparam logic [IR_W-1:0] IR_SAMPLE   = 4'h1;
    localparam logic [IR_W-1:0] IR_EXTEST   = 4'h2;
    localparam logic [IR_W-1:0] IR_INTEST   = 4'h3;
    localparam logic [IR_W-1:0] IR_RUNBIST  = 4'h4;
    localparam logic [IR_W-1:0] IR_IDCODE   = 4'h7;
    localparam logic [IR_W-1:0] IR_USERCODE = 4'h8;
    localparam logic [IR_W-1:0] IR_BYPASS   = 4'hF;

    typedef enum logic [3:0] {
        IDLE,
        TLR,
        IR_HDR,
        IR_SHIFT,
        IR_TAIL,
        DR_HDR,
        DR_SHIFT,
        DR_TAIL,
        FIN
    } state_t;

    // Pulses spent in each fixed-length phase; DR_SHIFT length comes from the command.
    function automatic logic [5:0] fixed_pulses(input state_t s);
        case (s)
            TLR:      return 6'd6;
            IR_HDR:   return 6'd4;
            IR_SHIFT: return 6'(IR_W);
            IR_TAIL:  return 6'd2;
            DR_HDR:   return 6'd3;
            DR_TAIL:  return 6'd2;
            default:  return 6'd1;
        endcase
    endfunction

endpackage

// File: rtl/tck_gen.sv
// TCK generator: toggles TCK every CLK_DIV clk cycles while enabled and
// flags the clk cycle in which TCK is about to rise or fall.
module tck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tck,
    output logic tck_rise,
    output logic tck_fall
);

    localparam logic [7:0] TERM = 8'(CLK_DIV - 1);

    logic [7:0] div_cnt;
    logic       tick;

    assign tick     = en && (div_cnt == TERM);
    assign tck_rise = tick && !tck;
    assign tck_fall = tick && tck;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            tck     <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            tck     <= 1'b0;
        end else if (tick) begin
            div_cnt <= '0;
            tck     <= ~tck;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/jtag_scan_master.sv
// JTAG scan master: optional Test-Logic-Reset, IR load, then a DR scan of up
// to DR_MAX bits, with the captured TDO bits returned right-aligned on dr_out.
module jtag_scan_master
    import jtag_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int DR_MAX  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              reset_tap,
    input  logic [IR_W-1:0]   ir_code,
    input  logic [5:0]        dr_len,
    input  logic [DR_MAX-1:0] dr_in,
    output logic              busy,
    output logic              done,
    output logic [DR_MAX-1:0] dr_out,
    output logic              TCK,
    output logic              TMS,
    output logic              TDI,
    input  logic              TDO
);

    localparam logic [5:0] LEN_MAX = 6'(DR_MAX);

    state_t            state, state_nxt;
    logic [5:0]        cnt, cnt_nxt;
    logic [5:0]        limit;
    logic              last;
    logic [IR_W-1:0]   ir_q;
    logic [5:0]        len_q, len_clamped;
    logic [DR_MAX-1:0] dr_q, cap, dr_sel;
    logic              tck_rise, tck_fall;
    logic              accept, advance;
    logic              tms_nxt, tdi_nxt;

    tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (busy),
        .tck      (TCK),
        .tck_rise (tck_rise),
        .tck_fall (tck_fall)
    );

    assign accept      = start && !busy;
    assign advance     = busy && tck_fall;
    assign len_clamped = ({26'd0, dr_len} > 32'(DR_MAX)) ? LEN_MAX : dr_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt is the pulse index inside the current phase; phases advance on TCK falls.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        limit     = (state == DR_SHIFT) ? len_q : fixed_pulses(state);
        last      = (cnt == limit - 6'd1);
        if (!busy) begin
            cnt_nxt = '0;
            if (accept) state_nxt = reset_tap ? TLR : IR_HDR;
            else        state_nxt = IDLE;
        end else if (tck_fall) begin
            if (!last) begin
                cnt_nxt = cnt + 6'd1;
            end else begin
                cnt_nxt = '0;
                case (state)
                    TLR:      state_nxt = IR_HDR;
                    IR_HDR:   state_nxt = IR_SHIFT;
                    IR_SHIFT: state_nxt = IR_TAIL;
                    IR_TAIL:  state_nxt = (len_q == 6'd0) ? FIN : DR_HDR;
                    DR_HDR:   state_nxt = DR_SHIFT;
                    DR_SHIFT: state_nxt = DR_TAIL;
                    DR_TAIL:  state_nxt = FIN;
                    default:  state_nxt = IDLE;
                endcase
            end
        end
    end

    // TMS/TDI are computed for the pulse about to start and registered on its launch.
    always_comb begin
        busy    = (state != IDLE) && (state != FIN);
        done    = (state == FIN);
        tms_nxt = 1'b0;
        tdi_nxt = 1'b0;
        dr_sel  = dr_q >> cnt_nxt;
        case (state_nxt)
            TLR:      tms_nxt = (cnt_nxt < 6'd5);
            IR_HDR:   tms_nxt = (cnt_nxt < 6'd2);
            IR_SHIFT: begin
                tms_nxt = (cnt_nxt == 6'(IR_W - 1));
                tdi_nxt = ir_q[cnt_nxt[1:0]];
            end
            IR_TAIL, DR_HDR, DR_TAIL: tms_nxt = (cnt_nxt == 6'd0);
            DR_SHIFT: begin
                tms_nxt = (cnt_nxt == len_q - 6'd1);
                tdi_nxt = dr_sel[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q   <= '0;
            len_q  <= '0;
            dr_q   <= '0;
            cap    <= '0;
            dr_out <= '0;
            TMS    <= 1'b1;
            TDI    <= 1'b0;
        end else begin
            if (accept) begin
                ir_q  <= ir_code;
                len_q <= len_clamped;
                dr_q  <= dr_in;
                cap   <= '0;
            end else if (busy && tck_rise && state == DR_SHIFT) begin
                cap <= cap | ({{(DR_MAX-1){1'b0}}, TDO} << cnt);
            end
            if (accept || advance) begin
                TMS <= tms_nxt;
                TDI <= tdi_nxt;
            end
            if (busy && state_nxt == FIN) dr_out <= cap;
        end
    end

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: a behavioural TAP target, a command driver,
// and a done-triggered scoreboard fed by an arithmetic reference model.
module tb_jtag_scan_master;

  localparam int CLK_DIV = 3;
  localparam int DR_MAX = 32;
  localparam logic [31:0] ID_VAL = 32'h1234_5093;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic reset_tap = 1'b0;
  logic [3:0] ir_code = 4'h0;
  logic [5:0] dr_len = 6'd0;
  logic [31:0] dr_in = 32'd0;
  logic busy, done;
  logic [31:0] dr_out;
  logic TCK, TMS, TDI, TDO;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  jtag_scan_master #(.CLK_DIV(CLK_DIV), .DR_MAX(DR_MAX)) dut (
    .clk(clk), .rst(rst), .start(start), .reset_tap(reset_tap),
    .ir_code(ir_code), .dr_len(dr_len), .dr_in(dr_in),
    .busy(busy), .done(done), .dr_out(dr_out),
    .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- TAP target model ----------------
  typedef enum logic [3:0] {
    T_TLR, T_RTI, T_SEL_DR, T_CAP_DR, T_SH_DR, T_EX1_DR, T_PA_DR, T_EX2_DR, T_UP_DR,
    T_SEL_IR, T_CAP_IR, T_SH_IR, T_EX1_IR, T_PA_IR, T_EX2_IR, T_UP_IR
  } tap_t;

  tap_t tap_st = T_TLR;
  logic [3:0] tap_ir = 4'h7;
  logic [3:0] ir_sr = 4'h0;
  logic [31:0] dr_sr = 32'd0;
  int dr_w = 32;
  logic [31:0] bsr_val = 32'd0;
  logic tdo_r = 1'b0;
  assign TDO = tdo_r;

  function automatic tap_t tap_next(input tap_t s, input logic tms);
    case (s)
      T_TLR:    return tms ? T_TLR    : T_RTI;
      T_RTI:    return tms ? T_SEL_DR : T_RTI;
      T_SEL_DR: return tms ? T_SEL_IR : T_CAP_DR;
      T_CAP_DR: return tms ? T_EX1_DR : T_SH_DR;
      T_SH_DR:  return tms ? T_EX1_DR : T_SH_DR;
      T_EX1_DR: return tms ? T_UP_DR  : T_PA_DR;
      T_PA_DR:  return tms ? T_EX2_DR : T_PA_DR;
      T_EX2_DR: return tms ? T_UP_DR  : T_SH_DR;
      T_UP_DR:  return tms ? T_SEL_DR : T_RTI;
      T_SEL_IR: return tms ? T_TLR    : T_CAP_IR;
      T_CAP_IR: return tms ? T_EX1_IR : T_SH_IR;
      T_SH_IR:  return tms ? T_EX1_IR : T_SH_IR;
      T_EX1_IR: return tms ? T_UP_IR  : T_PA_IR;
      T_PA_IR:  return tms ? T_EX2_IR : T_PA_IR;
      T_EX2_IR: return tms ? T_UP_IR  : T_SH_IR;
      default:  return tms ? T_SEL_DR : T_RTI;
    endcase
  endfunction

  always @(posedge TCK) begin
    case (tap_st)
      T_TLR: tap_ir = 4'h7;
      T_CAP_DR: begin
        if (tap_ir == 4'h7) begin dr_sr = ID_VAL; dr_w = 32; end
        else if (tap_ir == 4'hF) begin dr_sr = 32'd0; dr_w = 1; end
        else begin dr_sr = bsr_val; dr_w = 32; end
      end
      T_SH_DR:  dr_sr = (dr_sr >> 1) | (32'(TDI) << (dr_w - 1));
      T_CAP_IR: ir_sr = 4'b0001;
      T_SH_IR:  ir_sr = {TDI, ir_sr[3:1]};
      T_UP_IR:  tap_ir = ir_sr;
      default: ;
    endcase
    tap_st = tap_next(tap_st, TMS);
  end

  always @(negedge TCK) begin
    tdo_r = (tap_st == T_SH_DR) ? dr_sr[0] : (tap_st == T_SH_IR) ? ir_sr[0] : 1'b0;
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_dr(input logic [3:0] ir, input int len,
                                           input logic [31:0] din, input logic [31:0] bsr);
    logic [31:0] mask, raw;
    mask = (len >= 32) ? 32'hFFFF_FFFF : ((32'd1 << len) - 32'd1);
    if (ir == 4'h7) raw = ID_VAL;
    else if (ir == 4'hF) raw = din << 1;
    else raw = bsr;
    return raw & mask;
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [7:0] exp_pulse_q[$];
  logic [3:0] exp_ir_q[$];

  int pulse_cnt = 0;
  int hp = 0;
  logic prev_tck = 1'b0, prev_busy = 1'b0, prev_tms = 1'b1, prev_tdi = 1'b0, prev_rst = 1'b1;

  always @(negedge clk) begin
    if (rst || prev_rst) begin
      pulse_cnt = 0;
      hp = 0;
    end else begin
      if (TCK && !prev_tck) pulse_cnt++;
      if (busy || prev_busy) begin
        if (TCK != prev_tck) begin
          check("tck_half_period", hp, CLK_DIV);
          hp = 1;
        end else begin
          hp++;
        end
      end else begin
        hp = 0;
        check("tck_idle_low", {31'd0, TCK}, 32'd0);
      end
      if (TMS != prev_tms || TDI != prev_tdi)
        check("tms_tdi_on_fall", {31'd0, (prev_tck && !TCK) || !prev_busy}, 32'd1);
      if (done) begin
        check("busy_low_at_done", {31'd0, busy}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          check("dr_out", dr_out, exp_q.pop_front());
          check("tck_pulses", pulse_cnt, {24'd0, exp_pulse_q.pop_front()});
          check("tap_ir", {28'd0, tap_ir}, {28'd0, exp_ir_q.pop_front()});
          check("tap_in_rti", {31'd0, tap_st == T_RTI}, 32'd1);
          check("tms_low_at_done", {31'd0, TMS}, 32'd0);
        end
        pulse_cnt = 0;
      end
    end
    prev_tck = TCK;
    prev_busy = busy;
    prev_tms = TMS;
    prev_tdi = TDI;
    prev_rst = rst;
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic rt, input logic [3:0] ir, input logic [5:0] len,
                       input logic [31:0] din);
    int eff, n, pulses;
    n = 0;
    @(negedge clk);
    while (busy && n < 2000) begin @(negedge clk); n++; end
    eff = (int'(len) > DR_MAX) ? DR_MAX : int'(len);
    pulses = 10 + ((eff > 0) ? eff + 5 : 0) + (rt ? 6 : 0);
    start = 1'b1; reset_tap = rt; ir_code = ir; dr_len = len; dr_in = din;
    exp_q.push_back(model_dr(ir, eff, din, bsr_val));
    exp_pulse_q.push_back(8'(pulses));
    exp_ir_q.push_back(ir);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (done !== 1'b1 && n < limit) begin @(negedge clk); n++; end
    check("done_within_budget", {31'd0, done === 1'b1}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] ir_tab [7] = '{4'h7, 4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8};

  initial begin
    int n;
    logic [3:0] ir;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_tck", {31'd0, TCK}, 32'd0);
    check("rst_tms", {31'd0, TMS}, 32'd1);
    check("rst_tdi", {31'd0, TDI}, 32'd0);
    check("rst_dr_out", dr_out, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // IDCODE with TAP reset
    bsr_val = $urandom;
    issue(1'b1, 4'h7, 6'd32, $urandom);
    wait_done(3000);
    check("idcode_value", dr_out, 32'h1234_5093);

    // BYPASS, 8 bits
    issue(1'b0, 4'hF, 6'd8, 32'hA5);
    wait_done(3000);
    check("bypass_value", dr_out, 32'h4A);

    // IR only, no DR scan
    issue(1'b0, 4'h4, 6'd0, $urandom);
    wait_done(3000);
    check("irlen0_dr_out", dr_out, 32'd0);

    // over-long scan with a start pulse while busy
    bsr_val = $urandom;
    issue(1'b0, 4'h2, 6'd40, $urandom);
    repeat (20) @(negedge clk);
    check("busy_mid_cmd", {31'd0, busy}, 32'd1);
    start = 1'b1; reset_tap = 1'b1; ir_code = 4'hF; dr_len = 6'd5; dr_in = $urandom;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(3000);
    check("clamp_value", dr_out, bsr_val);
    repeat (60) @(negedge clk);
    check("single_done_busy", {31'd0, busy}, 32'd0);

    // reset in the middle of DR shifting
    issue(1'b1, 4'h7, 6'd32, $urandom);
    n = 0;
    while (!(pulse_cnt >= 30 && TCK === 1'b1) && n < 3000) begin @(negedge clk); n++; end
    check("reach_dr_shift", {31'd0, n < 3000}, 32'd1);
    #2 rst = 1'b1;
    exp_q.delete();
    exp_pulse_q.delete();
    exp_ir_q.delete();
    #1;
    check("abort_tck", {31'd0, TCK}, 32'd0);
    check("abort_tms", {31'd0, TMS}, 32'd1);
    check("abort_tdi", {31'd0, TDI}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_dr_out", dr_out, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    issue(1'b1, 4'h7, 6'd32, $urandom);
    wait_done(3000);
    check("post_abort_idcode", dr_out, 32'h1234_5093);

    // randomized commands
    for (int i = 0; i < 14; i++) begin
      ir = ir_tab[$urandom_range(0, 6)];
      bsr_val = $urandom;
      issue(1'($urandom_range(0, 1)), ir, 6'($urandom_range(0, 40)), $urandom);
      wait_done(3000);
    end

    repeat (30) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
